// File: rtl/gpio_pkg.sv
// Register map for the GPIO peripheral: byte offsets and the index
// (addr[5:3]) each offset decodes to.
package gpio_pkg;

   localparam logic [5:0] OFF_LED  = 6'h00;
   localparam logic [5:0] OFF_SW   = 6'h08;
   localparam logic [5:0] OFF_BTN  = 6'h10;
   localparam logic [5:0] OFF_EDGE = 6'h18;
   localparam logic [5:0] OFF_MASK = 6'h20;

   typedef enum logic [2:0] {
      REG_LED  = OFF_LED[5:3],
      REG_SW   = OFF_SW[5:3],
      REG_BTN  = OFF_BTN[5:3],
      REG_EDGE = OFF_EDGE[5:3],
      REG_MASK = OFF_MASK[5:3]
   } reg_idx_e;

endpackage

// File: rtl/gpio_debounce.sv
// One-bit input conditioner: two-flop synchronizer followed by a
// counter debouncer that accepts a new level after DEBOUNCE_CYCLES stable cycles.
module gpio_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_sync,
   output logic o_db
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

   logic          r_s1;
   logic          r_s2;
   logic          r_db;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   assign w_cnt_nxt = r_cnt + CW'(1);

   // The counter clears on the same edge the level is accepted, so it never exceeds LIMIT-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_db  <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
         if (r_s2 == r_db) begin
            r_cnt <= '0;
         end else if (w_cnt_nxt == LIMIT) begin
            r_db  <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= w_cnt_nxt;
         end
      end
   end

   assign o_sync = r_s2;
   assign o_db   = r_db;

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: LED register, debounced switches/buttons, sticky button
// edge flags (W1C). Define GPIO_IRQ_EN to add IRQ_MASK and a registered irq.
module gpio_mmio
   import gpio_pkg::*;
#(
   parameter int WIDTH           = 64,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             we,
   input  logic [5:0]       addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   input  logic [3:0]       btn,
   input  logic [3:0]       sw,
   output logic [3:0]       led,
   output logic             irq
);

   logic [7:0] w_raw;
   logic [7:0] w_sync;
   logic [7:0] w_db;
   logic [3:0] w_btn_db;
   logic [3:0] w_sw_db;
   logic [3:0] w_rise;
   logic [3:0] w_clr;
   logic [3:0] w_rd4;
   logic [2:0] w_idx;
   logic       w_wr;
   logic       w_unused;

   logic [1:0] r_vld;
   logic [3:0] r_arm;
   logic [3:0] r_btn_db_d;
   logic [3:0] r_led;
   logic [3:0] r_edge;

   assign w_raw = {btn, sw};

   for (genvar g = 0; g < 8; g++) begin : g_deb
      gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .i_raw (w_raw[g]),
         .o_sync(w_sync[g]),
         .o_db  (w_db[g])
      );
   end

   assign w_sw_db  = w_db[3:0];
   assign w_btn_db = w_db[7:4];
   assign w_idx    = addr[5:3];
   assign w_wr     = sel & we;
   assign w_unused = ^{addr[2:0], wdata[WIDTH-1:4], w_sync[3:0]};

   // A button only arms once its synchronized level has been seen low after reset,
   // so a button held through reset never produces a spurious edge.
   assign w_rise = w_btn_db & ~r_btn_db_d & r_arm;
   assign w_clr  = (w_wr && w_idx == REG_EDGE) ? wdata[3:0] : 4'h0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld      <= 2'b00;
         r_arm      <= 4'h0;
         r_btn_db_d <= 4'h0;
         r_led      <= 4'h0;
         r_edge     <= 4'h0;
      end else begin
         r_vld      <= {r_vld[0], 1'b1};
         if (r_vld[1]) r_arm <= r_arm | ~w_sync[7:4];
         r_btn_db_d <= w_btn_db;
         if (w_wr && w_idx == REG_LED) r_led <= wdata[3:0];
         r_edge     <= (r_edge & ~w_clr) | w_rise;
      end
   end

`ifdef GPIO_IRQ_EN
   logic [3:0] r_mask;
   logic       r_irq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mask <= 4'h0;
         r_irq  <= 1'b0;
      end else begin
         if (w_wr && w_idx == REG_MASK) r_mask <= wdata[3:0];
         r_irq <= |(r_edge & r_mask);
      end
   end

   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      w_rd4 = 4'h0;
      if (sel) begin
         case (w_idx)
            REG_LED:  w_rd4 = r_led;
            REG_SW:   w_rd4 = w_sw_db;
            REG_BTN:  w_rd4 = w_btn_db;
            REG_EDGE: w_rd4 = r_edge;
`ifdef GPIO_IRQ_EN
            REG_MASK: w_rd4 = r_mask;
`endif
            default:  w_rd4 = 4'h0;
         endcase
      end
   end

   always_comb begin
      rdata      = '0;
      rdata[3:0] = w_rd4;
   end

   assign led = r_led;

endmodule

// File: doc/gpio_mmio.md
GPIO_MMIO -- requirements
Module: gpio_mmio

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, giving the data-bus width in bits.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the stable-input cycles required before a debounced bit changes (minimum 1).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset; asynchronous, active-high.
REQ-005 Port sel, input, 1 bit: core access targets this peripheral.
REQ-006 Port we, input, 1 bit: write strobe, valid only when sel=1.
REQ-007 Port addr, input, 6 bits: byte offset into the register map.
REQ-008 Port wdata, input, WIDTH bits: core write data.
REQ-009 Port rdata, output, WIDTH bits: core read data.
REQ-010 Port btn, input, 4 bits: raw asynchronous push-buttons.
REQ-011 Port sw, input, 4 bits: raw asynchronous slide switches.
REQ-012 Port led, output, 4 bits: LED drive.
REQ-013 Port irq, output, 1 bit: level interrupt request.

Function
REQ-014 Register map, selected by addr[5:3] (addr[2:0] ignored): 0x00 LED (RW, bits[3:0]), 0x08 SW (RO), 0x10 BTN (RO), 0x18 BTN_EDGE (R/W1C), 0x20 IRQ_MASK (RW, bits[3:0]); other offsets read 0 and ignore writes.
REQ-015 rdata SHALL be combinational from sel/addr and current register state (zero-cycle read latency); unused upper bits zero; rdata=0 when sel=0.
REQ-016 Writes SHALL take effect on the rising clk edge where sel=1 and we=1; writes to RO registers are ignored.
REQ-017 led SHALL equal the LED register directly.
REQ-018 Each btn and sw bit SHALL pass a two-flop synchronizer, then a debouncer.
REQ-019 Debouncer: per-bit counter; it resets to 0 whenever the synchronized input equals the debounced value, otherwise increments. When it reaches DEBOUNCE_CYCLES, the debounced value takes the input and the counter clears.
REQ-020 Debounced-bit latency after a clean input step SHALL be exactly 2 + DEBOUNCE_CYCLES cycles; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL cause no change.
REQ-021 The counter SHALL be width $clog2(DEBOUNCE_CYCLES+1) and SHALL never wrap.
REQ-022 A BTN_EDGE bit SHALL be set in the cycle after its debounced button goes 0->1 and SHALL stay set until cleared by writing 1 to that bit.
REQ-023 On the same cycle, a set SHALL override a W1C clear of the same bit.

Reset
REQ-024 While rst=1: LED, BTN_EDGE and IRQ_MASK =0; synchronizers, debounced values and counters =0; hence led=0, irq=0, and rdata reads 0 from every register.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; no edge SHALL be captured from the post-reset state of an already-held button until it is seen as 0 and then 1.

Configuration
REQ-026 With macro GPIO_IRQ_EN defined: IRQ_MASK is implemented, and irq = |(BTN_EDGE & IRQ_MASK), registered (asserted one cycle after the term goes nonzero).
REQ-027 Without GPIO_IRQ_EN: no IRQ_MASK storage, offset 0x20 reads 0 and ignores writes, irq is tied 0; the port list is unchanged.

Structure
REQ-028 Package gpio_pkg SHALL hold the register-offset constants and a register-index enum.
REQ-029 Sub-module gpio_debounce (one bit: synchronizer + counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated 8 times.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-030 Reset: assert rst with btn=4'hF and sw=4'hF -> led=0, irq=0, and every offset reads 0 while rst=1.
REQ-031 LED write: write 0xA to 0x00 -> led=4'hA after the edge; read 0x00 returns 0xA; write 0x08 -> SW value unchanged.
REQ-032 Debounce: sw 0->4'h5 step -> read 0x08 returns 5 exactly 6 cycles later; 3-cycle glitch on sw[1] -> SW unchanged.
REQ-033 Edge capture: press btn[2] -> BTN_EDGE=4'h4; a W1C write of 0x4 in the same cycle as a new btn[0] edge -> BTN_EDGE=4'h1.
REQ-034 IRQ (GPIO_IRQ_EN): IRQ_MASK=4'h4, press btn[2] -> irq=1 one cycle after the edge bit sets; W1C 0x4 -> irq=0 the next cycle. Without the macro, irq stays 0.
REQ-035 Reset mid-operation: rst pulse during the count with btn[3] held -> no BTN_EDGE bit after rst deasserts; release and re-press -> bit 3 sets.
